// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// Module   : register_file
// Purpose  : 2**ADDRSIZE x DATASIZE register bank, one synchronous write port,
//            two enabled combinational read ports. Optional write-through
//            bypass when REGFILE_BYPASS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module register_file #(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wrenb,
    input  logic                r1enb,
    input  logic                r2enb,
    input  logic [ADDRSIZE-1:0] waddr,
    input  logic [ADDRSIZE-1:0] r1add,
    input  logic [ADDRSIZE-1:0] r2add,
    input  logic [DATASIZE-1:0] wdata,
    output logic [DATASIZE-1:0] r1dat,
    output logic [DATASIZE-1:0] r2dat
);

    localparam int REGCOUNT = 2 ** ADDRSIZE;

    logic [DATASIZE-1:0] w_regs [REGCOUNT];

    generate
        for (genvar gi = 0; gi < REGCOUNT; gi++) begin : g_reg
            logic [DATASIZE-1:0] r_data;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_data <= '0;
                end else if (wrenb && (waddr == ADDRSIZE'(gi))) begin
                    r_data <= wdata;
                end
            end

            assign w_regs[gi] = r_data;
        end
    endgenerate

    // Bypass is suppressed during reset because that write will be discarded.
    always_comb begin
        r1dat = '0;
        if (r1enb) begin
            r1dat = w_regs[r1add];
`ifdef REGFILE_BYPASS_EN
            if (wrenb && !rst && (r1add == waddr)) begin
                r1dat = wdata;
            end
`endif
        end
    end

    always_comb begin
        r2dat = '0;
        if (r2enb) begin
            r2dat = w_regs[r2add];
`ifdef REGFILE_BYPASS_EN
            if (wrenb && !rst && (r2add == waddr)) begin
                r2dat = wdata;
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_register_file
// Purpose  : directed, scoreboard-based self-checking bench for register_file
// Revision : 1.0 - initial release
// ============================================================================
module tb_register_file;

    logic       clk = 1'b0;
    logic       rst;
    logic       wrenb;
    logic       r1enb;
    logic       r2enb;
    logic [2:0] waddr;
    logic [2:0] r1add;
    logic [2:0] r2add;
    logic [7:0] wdata;
    logic [7:0] r1dat;
    logic [7:0] r2dat;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] exp_q [$];
    logic [7:0] model [8];

    always #5 clk = ~clk;

    register_file #(
        .DATASIZE(8),
        .ADDRSIZE(3)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .wrenb(wrenb),
        .r1enb(r1enb),
        .r2enb(r2enb),
        .waddr(waddr),
        .r1add(r1add),
        .r2add(r2add),
        .wdata(wdata),
        .r1dat(r1dat),
        .r2dat(r2dat)
    );

    task automatic check(input string tag, input logic [7:0] observed);
        logic [7:0] expected;
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL %s: scoreboard empty, observed %h", tag, observed);
        end else begin
            expected = exp_q.pop_front();
            vectors++;
            assert (observed === expected)
            else begin
                miscompares++;
                $error("FAIL %s: observed %h expected %h", tag, observed, expected);
            end
        end
    endtask

    // Drive both read ports, queue expected data, compare after settling.
    task automatic read2(input string tag,
                         input logic e1, input logic [2:0] a1, input logic [7:0] x1,
                         input logic e2, input logic [2:0] a2, input logic [7:0] x2);
        r1enb = e1; r1add = a1;
        r2enb = e2; r2add = a2;
        exp_q.push_back(x1);
        exp_q.push_back(x2);
        #1;
        check({tag, "_r1"}, r1dat);
        check({tag, "_r2"}, r2dat);
    endtask

    task automatic do_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        wrenb = 1'b1; waddr = a; wdata = d;
        @(posedge clk);
        #1;
        wrenb = 1'b0;
        model[a] = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; wrenb = 1'b0; r1enb = 1'b0; r2enb = 1'b0;
        waddr = '0; r1add = '0; r2add = '0; wdata = '0;
        for (int i = 0; i < 8; i++) model[i] = 8'h00;

        // Reset held 5 cycles while writes are being attempted
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            wrenb = 1'b1; waddr = 3'(i); wdata = 8'($urandom_range(1, 255));
        end
        @(negedge clk);
        rst = 1'b0; wrenb = 1'b0;
        for (int a = 0; a < 8; a++) read2("rst_sweep", 1'b1, 3'(a), 8'h00, 1'b1, 3'(7 - a), 8'h00);
        read2("rst_dis", 1'b0, 3'd0, 8'h00, 1'b0, 3'd1, 8'h00);

        // Single write to reg 0, others untouched
        do_write(3'd0, 8'hAA);
        read2("w0_aa", 1'b1, 3'd0, 8'hAA, 1'b0, 3'd0, 8'h00);
        for (int a = 1; a < 8; a++) read2("w0_others", 1'b1, 3'(a), 8'h00, 1'b1, 3'(a), 8'h00);

        // Overwrite reg 0, then toggle reg 1
        do_write(3'd0, 8'h55);
        read2("w0_55", 1'b1, 3'd0, 8'h55, 1'b0, 3'd0, 8'h00);
        do_write(3'd1, 8'hAA);
        read2("w1_aa", 1'b1, 3'd1, 8'hAA, 1'b1, 3'd0, 8'h55);
        do_write(3'd1, 8'h55);
        read2("w1_55", 1'b1, 3'd1, 8'h55, 1'b1, 3'd0, 8'h55);

        // Dual read, then disable port 2
        do_write(3'd2, 8'h12);
        do_write(3'd5, 8'h34);
        read2("dual", 1'b1, 3'd2, 8'h12, 1'b1, 3'd5, 8'h34);
        read2("r2_off", 1'b1, 3'd2, 8'h12, 1'b0, 3'd5, 8'h00);
        read2("r1_off", 1'b0, 3'd2, 8'h00, 1'b1, 3'd5, 8'h34);
        read2("same_addr", 1'b1, 3'd5, 8'h34, 1'b1, 3'd5, 8'h34);
        for (int a = 0; a < 8; a++) read2("model_sweep", 1'b1, 3'(a), model[a], 1'b1, 3'(a), model[a]);

        // Reset beats a simultaneous write; no bypass while in reset
        do_write(3'd3, 8'h77);
        @(negedge clk);
        rst = 1'b1; wrenb = 1'b1; waddr = 3'd3; wdata = 8'hFF;
        read2("rst_wr_pre", 1'b1, 3'd3, 8'h77, 1'b1, 3'd0, 8'h55);
        @(posedge clk);
        #1;
        rst = 1'b0; wrenb = 1'b0;
        for (int i = 0; i < 8; i++) model[i] = 8'h00;
        read2("rst_wr_post", 1'b1, 3'd3, 8'h00, 1'b1, 3'd0, 8'h00);
        read2("rst_wr_post2", 1'b1, 3'd5, 8'h00, 1'b1, 3'd1, 8'h00);

        // Same-address read during write, reg 4: 0x11 -> 0x22
        do_write(3'd4, 8'h11);
        @(negedge clk);
        wrenb = 1'b1; waddr = 3'd4; wdata = 8'h22;
`ifdef REGFILE_BYPASS_EN
        read2("rdw_pre", 1'b1, 3'd4, 8'h22, 1'b1, 3'd4, 8'h22);
`else
        read2("rdw_pre", 1'b1, 3'd4, 8'h11, 1'b1, 3'd4, 8'h11);
`endif
        read2("rdw_other", 1'b1, 3'd3, 8'h00, 1'b0, 3'd4, 8'h00);
        @(posedge clk);
        #1;
        wrenb = 1'b0;
        model[4] = 8'h22;
        read2("rdw_post", 1'b1, 3'd4, 8'h22, 1'b1, 3'd4, 8'h22);
        for (int a = 0; a < 8; a++) read2("final_sweep", 1'b1, 3'(a), model[a], 1'b1, 3'(7 - a), model[7 - a]);

        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
